// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART RX/TX byte FIFOs.
// Provides default byte width and FIFO pointer width.
package uart_rx_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer/producer bundle for the RX FIFO.
// slave: FIFO side (i_* in, o_* out); master: receiver/consumer side.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  i_push;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_pop;
  logic                  i_clr_err;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_empty;
  logic                  o_full;
  logic [ADDR_WIDTH:0]   o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport slave (
    input  i_push, i_wdata, i_pop, i_clr_err,
    output o_rdata, o_empty, o_full, o_count,
    output o_overflow, o_underflow
  );

  modport master (
    output i_push, i_wdata, i_pop, i_clr_err,
    input  o_rdata, o_empty, o_full, o_count,
    input  o_overflow, o_underflow
  );

endinterface

// File: rtl/fifo_regfile.sv
// FIFO storage array: one sync write port, one async read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module fifo_regfile
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive byte FIFO with occupancy and sticky error flags.
// Ports: clk, rst (async, active-low), bus (uart_rx_fifo_if.slave).
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic empty, full;
  logic push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop on a full FIFO frees the slot the push needs.
  assign push_ok = bus.i_push & (~full | bus.i_pop);
  assign pop_ok  = bus.i_pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Clear wins over a same-cycle set.
  always_comb begin
    ovf_d = ovf_q | (bus.i_push & ~push_ok);
    udf_d = udf_q | (bus.i_pop & empty);
    if (bus.i_clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.i_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.o_rdata)
  );

  assign bus.o_empty     = empty;
  assign bus.o_full      = full;
  assign bus.o_count     = count_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Stimulus queues expected bytes; a monitor checks each pop.
module tb_uart_rx_fifo;

  logic clk;
  logic rst;

  uart_rx_fifo_if u_if ();

  uart_rx_fifo u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are stable at negedge; a pop of a non-empty FIFO
  // must present the oldest expected byte on o_rdata.
  always @(negedge clk) begin
    if (rst && u_if.i_pop && !u_if.o_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none",
                 u_if.o_rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (u_if.o_rdata !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h",
                   u_if.o_rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [7:0] b, input bit acc);
    u_if.i_push  = 1'b1;
    u_if.i_wdata = b;
    if (acc) exp_q.push_back(b);
    step();
    u_if.i_push = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      u_if.i_pop = 1'b1;
      step();
      u_if.i_pop = 1'b0;
    end
  endtask

  task automatic clr();
    u_if.i_clr_err = 1'b1;
    step();
    u_if.i_clr_err = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    u_if.i_push    = 1'b0;
    u_if.i_wdata   = '0;
    u_if.i_pop     = 1'b0;
    u_if.i_clr_err = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();

    chk("rst_empty", 32'(u_if.o_empty), 1);
    chk("rst_full", 32'(u_if.o_full), 0);
    chk("rst_count", 32'(u_if.o_count), 0);
    chk("rst_ovf", 32'(u_if.o_overflow), 0);
    chk("rst_udf", 32'(u_if.o_underflow), 0);

    push_b(8'h41, 1);
    chk("lat_empty", 32'(u_if.o_empty), 0);
    chk("lat_rdata", 32'(u_if.o_rdata), 32'h41);
    push_b(8'h42, 1);
    push_b(8'h43, 1);
    chk("abc_count", 32'(u_if.o_count), 3);
    pop_n(1);
    chk("abc_count2", 32'(u_if.o_count), 2);
    pop_n(2);
    chk("abc_count0", 32'(u_if.o_count), 0);
    chk("abc_empty", 32'(u_if.o_empty), 1);

    for (int i = 0; i < 16; i++) push_b(8'(i), 1);
    chk("fill_full", 32'(u_if.o_full), 1);
    chk("fill_count", 32'(u_if.o_count), 16);
    push_b(8'hAA, 0);
    chk("ovf_set", 32'(u_if.o_overflow), 1);
    chk("ovf_count", 32'(u_if.o_count), 16);
    pop_n(16);
    chk("ovf_drain", 32'(u_if.o_empty), 1);
    clr();
    chk("ovf_clr", 32'(u_if.o_overflow), 0);

    for (int i = 0; i < 16; i++) push_b(8'h20 + 8'(i), 1);
    u_if.i_pop = 1'b1;
    push_b(8'h55, 1);
    u_if.i_pop = 1'b0;
    chk("fullpp_count", 32'(u_if.o_count), 16);
    chk("fullpp_ovf", 32'(u_if.o_overflow), 0);
    pop_n(16);
    chk("fullpp_empty", 32'(u_if.o_empty), 1);

    pop_n(1);
    chk("udf_set", 32'(u_if.o_underflow), 1);
    chk("udf_count", 32'(u_if.o_count), 0);
    u_if.i_clr_err = 1'b1;
    pop_n(1);
    u_if.i_clr_err = 1'b0;
    chk("udf_clr_prio", 32'(u_if.o_underflow), 0);

    u_if.i_pop = 1'b1;
    push_b(8'h77, 1);
    u_if.i_pop = 1'b0;
    chk("emptypp_count", 32'(u_if.o_count), 1);
    chk("emptypp_udf", 32'(u_if.o_underflow), 1);
    clr();
    pop_n(1);

    for (int i = 0; i < 5; i++) push_b(8'h60 + 8'(i), 1);
    chk("pre_rst_count", 32'(u_if.o_count), 5);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_empty", 32'(u_if.o_empty), 1);
    chk("mid_rst_count", 32'(u_if.o_count), 0);
    chk("mid_rst_full", 32'(u_if.o_full), 0);
    step();
    rst = 1'b1;
    step();
    push_b(8'h99, 1);
    chk("post_rst_rdata", 32'(u_if.o_rdata), 32'h99);
    chk("post_rst_count", 32'(u_if.o_count), 1);
    pop_n(1);

    push_b(8'hC0, 1);
    u_if.i_pop = 1'b1;
    for (int i = 0; i < 40; i++) push_b(8'h80 + 8'(i), 1);
    u_if.i_pop = 1'b0;
    chk("wrap_count", 32'(u_if.o_count), 1);
    pop_n(1);
    chk("wrap_empty", 32'(u_if.o_empty), 1);

    step();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Each completed byte (one-cycle done strobe plus byte) is written into a synchronous first-word-fall-through FIFO. The consumer (CPU/loopback/TX path) drains it with a pop strobe. The block reports full, empty, occupancy, and sticky overflow/underflow errors, so bytes arriving at baud rate are never silently lost.

## Interface
- DATA_WIDTH, 8, byte width; matches the receiver output
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH = 16
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release handled upstream
- i_push  in  1  write strobe; driven by the receiver's rx_done (one cycle per byte)
- i_wdata  in  DATA_WIDTH  byte to write; sampled when i_push=1
- i_pop  in  1  read strobe; removes the head entry
- o_rdata  out  DATA_WIDTH  head entry (FWFT); valid while o_empty=0
- o_empty  out  1  no entries stored
- o_full  out  1  2**ADDR_WIDTH entries stored
- o_count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
- o_overflow  out  1  sticky; set on a push that is dropped because the FIFO is full
- o_underflow  out  1  sticky; set on a pop while the FIFO is empty
- i_clr_err  in  1  synchronous clear of both sticky flags

## Operation
- Storage: a 2**ADDR_WIDTH x DATA_WIDTH register array, write pointer wr_ptr, read pointer rd_ptr, and a count register. Each pointer is ADDR_WIDTH bits and wraps naturally from 15 to 0.
- Accepted push: when i_push=1 and (o_full=0 or i_pop=1), mem[wr_ptr] <= i_wdata and wr_ptr increments.
- Accepted pop: when i_pop=1 and o_empty=0, rd_ptr increments.
- Count update:
  - +1 on an accepted push alone.
  - -1 on an accepted pop alone.
  - Unchanged when both are accepted.
- Full with push and pop in the same cycle: both are accepted, count stays at 16, no overflow.
- Empty with push and pop in the same cycle: the push is accepted, the pop is ignored, underflow is set, and count becomes 1.
- Dropped push (full, no pop): the write is discarded, memory is not modified, o_overflow <= 1.
- Flags: o_empty = (count==0) and o_full = (count==2**ADDR_WIDTH). Both are decoded from the registered count, so there is no combinational path from i_push or i_pop.
- o_rdata = mem[rd_ptr], a combinational read of registered state. When empty, its value is undefined and must be ignored; the bench must not check it.
- Sticky error flags: i_clr_err has priority over a same-cycle set, so the flag reads 0 afterwards.
- No internal state machine. Control is fully pointer/count based. Data is never reordered; bytes leave in arrival order.

## Timing
- Reset (rst=0, asynchronous) clears wr_ptr, rd_ptr, count, o_overflow and o_underflow. As a result:
  - o_empty=1, o_full=0, o_count=0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored bytes immediately; there is no completion of an in-flight push.
- Write-to-read latency is 1 cycle. A push at edge N makes the byte visible on o_rdata, and clears o_empty, after edge N.
- A pop at edge N shows the next entry on o_rdata after edge N.
- Throughput: one push and one pop per cycle sustained. The receiver pushes at most once per 10 bit-times, so back-pressure towards it never arises; a drop is signalled by overflow only.
- o_count, o_full and o_empty all update on the same edge as the pointers.

## Structure
- Shared include/package: DATA_WIDTH default 8, FIFO ADDR_WIDTH default 4. The same constants are reused by the TX-side FIFO.
- Sub-module fifo_regfile: the register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- uart_rx_fifo holds pointers, count, flags and the accept logic. The TX FIFO instantiates the same fifo_regfile.

## Test plan
- Reset then idle: o_empty=1, o_full=0, o_count=0, o_overflow=0, o_underflow=0.
- Push 0x41, 0x42, 0x43 on single-cycle strobes, then pop three times. o_rdata reads 0x41, 0x42, 0x43 in order; o_count goes 3→0 and ends with o_empty=1.
- Push 16 bytes 0x00..0x0F (o_full=1, o_count=16), then push 0xAA. o_overflow=1, o_count stays 16, and the drained data is 0x00..0x0F with no 0xAA.
- Fill to 16, then push 0x55 with i_pop in the same cycle. o_count=16, no overflow, and the last byte drained is 0x55.
- Pop while empty: o_underflow=1. Then assert i_clr_err together with another empty pop: o_underflow=0.
- Fill to 5 entries, then pull rst low between clock edges. All outputs reset immediately. Push 0x99 after release: o_rdata=0x99, o_count=1 (pointer wrap is also exercised by 40 push/pop pairs with matching data).
